// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, ALU ops, FSM states and mux selects for the multicycle core
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_t;

   // OPC_REG honours funct7_5 for SUB and SRA; OPC_IMM only for SRAI
   typedef enum logic [1:0] {OPC_ADD, OPC_SUB, OPC_REG, OPC_IMM} alu_class_t;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
      S_LUI, S_AUIPC, S_ALUWB, S_JALRADR, S_JAL, S_BRANCH, S_HALT
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUREG = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps op class, funct3 and funct7_5 to an ALU operation
module alu_decoder
   import riscv_pkg::*;
(
   input  alu_class_t op_class_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   output alu_op_t    alu_op_o
);

   always_comb begin
      alu_op_o = ALU_ADD;
      case (op_class_i)
         OPC_ADD: alu_op_o = ALU_ADD;
         OPC_SUB: alu_op_o = ALU_SUB;
         default: begin
            case (funct3_i)
               3'b000:  alu_op_o = (op_class_i == OPC_REG && funct7_5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op_o = ALU_SLL;
               3'b010:  alu_op_o = ALU_SLT;
               3'b011:  alu_op_o = ALU_SLTU;
               3'b100:  alu_op_o = ALU_XOR;
               3'b101:  alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op_o = ALU_OR;
               default: alu_op_o = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main sequencing FSM of the multicycle RV32I core
module multicycle_controller
   import riscv_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       sign,
   input  logic       carry,
   input  logic       overflow,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_control,
   output logic [2:0] imm_src,
   output logic       reg_write,
   output logic       retire,
   output logic       halted,
   output logic       illegal
);

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s, retire_s, taken;
   alu_class_t op_class;
   alu_op_t    alu_op;

   alu_decoder u_alu_decoder (
      .op_class_i (op_class),
      .funct3_i   (funct3),
      .funct7_5_i (funct7_5),
      .alu_op_o   (alu_op)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      pc_write_s  = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      retire_s    = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUREG;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RD2;
      op_class    = OPC_ADD;
      taken       = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            // branch/jal target is computed here and parked in alu_reg
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_REG:            state_d = S_EXER;
               OP_IMM:            state_d = S_EXEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALRADR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               OP_SYSTEM:         state_d = S_HALT;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = RES_DATA;
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            adr_src     = 1'b1;
            mem_write_s = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
         end
         S_EXER: begin
            alu_src_a = SRCA_RD1;
            op_class  = OPC_REG;
            state_d   = S_ALUWB;
         end
         S_EXEI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            op_class  = OPC_IMM;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
         end
         S_JALRADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = S_JAL;
         end
         S_JAL: begin
            // pc takes the parked target while the ALU forms the link value
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write_s = 1'b1;
            state_d    = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_RD1;
            op_class  = OPC_SUB;
            retire_s  = 1'b1;
            case (funct3)
               3'b000: taken = zero;
               3'b001: taken = ~zero;
               3'b100: taken = sign ^ overflow;
               3'b101: taken = ~(sign ^ overflow);
               3'b110: taken = ~carry;
               3'b111: taken = carry;
               default: begin
                  taken     = 1'b0;
                  illegal_d = 1'b1;
               end
            endcase
            pc_write_s = taken;
            state_d    = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      imm_src = IMM_I;
      case (opcode)
         OP_STORE:        imm_src = IMM_S;
         OP_BRANCH:       imm_src = IMM_B;
         OP_LUI, OP_AUIPC: imm_src = IMM_U;
         OP_JAL:          imm_src = IMM_J;
         default:         imm_src = IMM_I;
      endcase
   end

   // strobes are forced low for the whole time reset is asserted
   assign pc_write    = reset & pc_write_s;
   assign mem_write   = reset & mem_write_s;
   assign ir_write    = reset & ir_write_s;
   assign reg_write   = reset & reg_write_s;
   assign retire      = reset & retire_s;
   assign alu_control = alu_op;
   assign halted      = (state_q == S_HALT);
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;
   import riscv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, zero, sign, carry, overflow;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, halted, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [3:0] alu_control;
   logic [2:0] imm_src;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .sign(sign), .carry(carry), .overflow(overflow),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
      .retire(retire), .halted(halted), .illegal(illegal)
   );

   typedef enum int {
      K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR, K_EXER, K_EXEI,
      K_LUI, K_AUIPC, K_ALUWB, K_JALRADR, K_JAL, K_BRANCH, K_HALT
   } step_t;

   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic       f7, z, s, c, v, tk;
      int         lat;
   } vec_t;

   int    nvec = 0;
   int    nmis = 0;
   logic  exp_illegal = 1'b0;
   step_t seq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [16:0] obs();
      return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
              alu_control, reg_write, retire, halted};
   endfunction

   function automatic logic [16:0] pk(input logic pcw, adr, mw, irw, input logic [1:0] res, a, b,
                                      input logic [3:0] op, input logic rw, ret, hlt);
      return {pcw, adr, mw, irw, res, a, b, op, rw, ret, hlt};
   endfunction

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_reg);
      case (f3)
         3'd0:    return (is_reg && f7) ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return f7 ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic bit known(input logic [6:0] o);
      return o inside {OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR,
                       OP_LUI, OP_AUIPC, OP_SYSTEM};
   endfunction

   function automatic logic [2:0] imm_ref(input logic [6:0] o);
      case (o)
         OP_STORE:         return 3'b001;
         OP_BRANCH:        return 3'b010;
         OP_LUI, OP_AUIPC: return 3'b011;
         OP_JAL:           return 3'b100;
         default:          return 3'b000;
      endcase
   endfunction

   function automatic int lat_of(input logic [6:0] o);
      case (o)
         OP_LOAD, OP_JALR: return 5;
         OP_BRANCH:        return 3;
         default:          return 4;
      endcase
   endfunction

   // expected values plus a mask of the fields the step actually defines
   function automatic void step_exp(input step_t k, input logic [2:0] f3, input logic f7,
                                    input logic tk, output logic [16:0] e, output logic [16:0] m);
      logic       ca, cb, cop, cres, cadr, pcw, adr, mw, irw, rw, ret, hlt;
      logic [1:0] a, b, res;
      logic [3:0] op;
      {ca, cb, cop, cres, cadr} = '0;
      {pcw, adr, mw, irw, rw, ret, hlt} = '0;
      a = 2'b00; b = 2'b00; res = 2'b00; op = ALU_ADD;
      case (k)
         K_FETCH:   begin irw = 1; pcw = 1; b = 2'b10; res = 2'b10; {ca, cb, cop, cres, cadr} = '1; end
         K_DECODE:  begin a = 2'b01; b = 2'b01; {ca, cb, cop} = '1; end
         K_MEMADR:  begin a = 2'b10; b = 2'b01; {ca, cb, cop} = '1; end
         K_MEMRD:   begin adr = 1; {cres, cadr} = '1; end
         K_MEMWB:   begin res = 2'b01; rw = 1; ret = 1; cres = 1; end
         K_MEMWR:   begin adr = 1; mw = 1; ret = 1; {cres, cadr} = '1; end
         K_EXER:    begin a = 2'b10; op = alu_ref(f3, f7, 1'b1); {ca, cb, cop} = '1; end
         K_EXEI:    begin a = 2'b10; b = 2'b01; op = alu_ref(f3, f7, 1'b0); {ca, cb, cop} = '1; end
         K_LUI:     begin a = 2'b11; b = 2'b01; {ca, cb, cop} = '1; end
         K_AUIPC:   begin a = 2'b01; b = 2'b01; {ca, cb, cop} = '1; end
         K_ALUWB:   begin rw = 1; ret = 1; cres = 1; end
         K_JALRADR: begin a = 2'b10; b = 2'b01; {ca, cb, cop} = '1; end
         K_JAL:     begin a = 2'b01; b = 2'b10; pcw = 1; {ca, cb, cop, cres} = '1; end
         K_BRANCH:  begin a = 2'b10; op = ALU_SUB; ret = 1; pcw = tk; {ca, cb, cop, cres} = '1; end
         default:   hlt = 1;
      endcase
      e = pk(pcw, adr, mw, irw, res, a, b, op, rw, ret, hlt);
      m = pk(1'b1, cadr, 1'b1, 1'b1, {2{cres}}, {2{ca}}, {2{cb}}, {4{cop}}, 1'b1, 1'b1, 1'b1);
   endfunction

   task automatic build_seq(input logic [6:0] o);
      seq.delete();
      seq.push_back(K_FETCH);
      seq.push_back(K_DECODE);
      case (o)
         OP_LOAD:   begin seq.push_back(K_MEMADR); seq.push_back(K_MEMRD); seq.push_back(K_MEMWB); end
         OP_STORE:  begin seq.push_back(K_MEMADR); seq.push_back(K_MEMWR); end
         OP_REG:    begin seq.push_back(K_EXER); seq.push_back(K_ALUWB); end
         OP_IMM:    begin seq.push_back(K_EXEI); seq.push_back(K_ALUWB); end
         OP_LUI:    begin seq.push_back(K_LUI); seq.push_back(K_ALUWB); end
         OP_AUIPC:  begin seq.push_back(K_AUIPC); seq.push_back(K_ALUWB); end
         OP_BRANCH: seq.push_back(K_BRANCH);
         OP_JAL:    begin seq.push_back(K_JAL); seq.push_back(K_ALUWB); end
         OP_JALR:   begin seq.push_back(K_JALRADR); seq.push_back(K_JAL); seq.push_back(K_ALUWB); end
         default:   seq.push_back(K_HALT);
      endcase
   endtask

   // nsteps < 0 runs the whole instruction and checks its latency
   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic z, s, c, v, tk, input int exp_lat, input int nsteps,
                            input string tag);
      logic [16:0] e, m;
      int          ret_at, n;
      opcode = opc; funct3 = f3; funct7_5 = f7;
      {zero, sign, carry, overflow} = {z, s, c, v};
      build_seq(opc);
      n = (nsteps < 0) ? seq.size() : nsteps;
      ret_at = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step_exp(seq[i], f3, f7, tk, e, m);
         check({tag, " outputs"}, {15'd0, obs() & m}, {15'd0, e & m});
         if (known(opc) && opc != OP_SYSTEM) check({tag, " imm_src"}, {29'd0, imm_src}, {29'd0, imm_ref(opc)});
         check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_illegal});
         if (retire && ret_at == 0) ret_at = i + 1;
         @(posedge clk); #1;
         if (seq[i] == K_DECODE && !known(opc)) exp_illegal = 1'b1;
         if (seq[i] == K_BRANCH && f3[2:1] == 2'b01) exp_illegal = 1'b1;
      end
      if (nsteps < 0) check({tag, " latency"}, ret_at, exp_lat);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("reset strobes", {27'd0, pc_write, mem_write, ir_write, reg_write, retire}, 32'd0);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      exp_illegal = 1'b0;
   endtask

   task automatic check_halt(input int n, input logic exp_ill, input string tag);
      logic [16:0] e, m;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step_exp(K_HALT, 3'd0, 1'b0, 1'b0, e, m);
         check({tag, " halt outputs"}, {15'd0, obs() & m}, {15'd0, e & m});
         check({tag, " halt illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
         @(posedge clk); #1;
      end
   endtask

   vec_t       tbl[18];
   logic [6:0] legal[9];

   initial begin
      logic [31:0] a, b;
      logic [32:0] r;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7, z, s, c, v, tk;

      reset = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
      zero = 1'b0; sign = 1'b0; carry = 1'b0; overflow = 1'b0;

      //           opc        f3      f7 z  s  c  v  tk lat
      tbl[0]  = '{OP_REG,    3'b000, 1, 0, 0, 0, 0, 0, 4};
      tbl[1]  = '{OP_REG,    3'b101, 1, 0, 0, 0, 0, 0, 4};
      tbl[2]  = '{OP_IMM,    3'b000, 1, 0, 0, 0, 0, 0, 4};
      tbl[3]  = '{OP_IMM,    3'b101, 1, 0, 0, 0, 0, 0, 4};
      tbl[4]  = '{OP_IMM,    3'b001, 0, 0, 0, 0, 0, 0, 4};
      tbl[5]  = '{OP_LOAD,   3'b010, 0, 0, 0, 0, 0, 0, 5};
      tbl[6]  = '{OP_STORE,  3'b010, 0, 0, 0, 0, 0, 0, 4};
      tbl[7]  = '{OP_BRANCH, 3'b000, 0, 1, 0, 0, 0, 1, 3};
      tbl[8]  = '{OP_BRANCH, 3'b110, 0, 0, 0, 1, 0, 0, 3};
      tbl[9]  = '{OP_BRANCH, 3'b100, 0, 0, 1, 0, 1, 0, 3};
      tbl[10] = '{OP_BRANCH, 3'b001, 0, 0, 0, 0, 0, 1, 3};
      tbl[11] = '{OP_BRANCH, 3'b111, 0, 0, 0, 1, 0, 1, 3};
      tbl[12] = '{OP_BRANCH, 3'b101, 0, 0, 1, 0, 0, 0, 3};
      tbl[13] = '{OP_JAL,    3'b000, 0, 0, 0, 0, 0, 0, 4};
      tbl[14] = '{OP_JALR,   3'b000, 0, 0, 0, 0, 0, 0, 5};
      tbl[15] = '{OP_LUI,    3'b000, 0, 0, 0, 0, 0, 0, 4};
      tbl[16] = '{OP_AUIPC,  3'b000, 0, 0, 0, 0, 0, 0, 4};
      tbl[17] = '{OP_BRANCH, 3'b011, 0, 1, 0, 0, 0, 0, 3};

      legal = '{OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

      do_reset(2);

      for (int i = 0; i < 18; i++)
         run_instr(tbl[i].opc, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].s, tbl[i].c, tbl[i].v,
                   tbl[i].tk, tbl[i].lat, -1, $sformatf("vec%0d", i));

      // reset asserted during the store's write cycle must suppress mem_write
      do_reset(1);
      run_instr(OP_STORE, 3'b010, 0, 0, 0, 0, 0, 0, 4, 3, "memwr prefix");
      reset = 1'b0;
      @(negedge clk);
      check("memwr reset mem_write", {31'd0, mem_write}, 32'd0);
      check("memwr reset retire", {31'd0, retire}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_illegal = 1'b0;
      run_instr(OP_LOAD, 3'b010, 0, 0, 0, 0, 0, 0, 5, -1, "after memwr reset");

      for (int n = 0; n < 200; n++) begin
         opc = legal[$urandom_range(0, 8)];
         f3  = 3'($urandom);
         f7  = 1'($urandom);
         tk  = 1'b0;
         if (opc == OP_BRANCH) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
            r = {1'b0, a} - {1'b0, b};
            z = (r[31:0] == 32'd0);
            s = r[31];
            c = ~r[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
            case (f3)
               3'd0:    tk = (a == b);
               3'd1:    tk = (a != b);
               3'd4:    tk = ($signed(a) <  $signed(b));
               3'd5:    tk = ($signed(a) >= $signed(b));
               3'd6:    tk = (a <  b);
               3'd7:    tk = (a >= b);
               default: tk = 1'b0;
            endcase
         end else begin
            {z, s, c, v} = 4'($urandom);
         end
         run_instr(opc, f3, f7, z, s, c, v, tk, lat_of(opc), -1, "rand");
      end

      // unknown opcode: sticky illegal and halt until reset
      do_reset(1);
      run_instr(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2, "illegal op");
      check_halt(20, 1'b1, "illegal op");
      do_reset(1);
      @(negedge clk);
      check("post-reset halted", {31'd0, halted}, 32'd0);
      check("post-reset illegal", {31'd0, illegal}, 32'd0);
      @(posedge clk); #1;
      do_reset(1);
      run_instr(OP_REG, 3'b110, 0, 0, 0, 0, 0, 0, 4, -1, "after halt");

      // ecall-style opcode halts without flagging illegal
      run_instr(OP_SYSTEM, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2, "system");
      check_halt(3, 1'b0, "system");
      do_reset(1);
      run_instr(OP_IMM, 3'b101, 0, 0, 0, 0, 0, 0, 4, -1, "after system");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
